// File: rtl/l2_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module : l2_mem_responder_pkg
// Brief  : Shared opcodes and responder state encoding for the L2 memory port.
// Rev    : 1.0  initial release
// ============================================================================
package l2_mem_responder_pkg;

    localparam logic [3:0] MEM_LD_LINE = 4'd4;
    localparam logic [3:0] MEM_ST_LINE = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_RESP  = 2'd2,
        ST_DRAIN = 2'd3
    } rsp_state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op == MEM_LD_LINE) || (op == MEM_ST_LINE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_line_ram.sv
`default_nettype none
// ============================================================================
// Module : mem_line_ram
// Brief  : Single-port line store, synchronous read with held output, no reset.
// Rev    : 1.0  initial release
// ============================================================================
module mem_line_ram #(
    parameter int WIDTH    = 512,
    parameter int DEPTH_LG = 10
) (
    input  logic                clk,
    input  logic                we,
    input  logic                re,
    input  logic [DEPTH_LG-1:0] addr,
    input  logic [WIDTH-1:0]    wdata,
    output logic [WIDTH-1:0]    rdata
);

    logic [WIDTH-1:0] mem_q [2**DEPTH_LG];
    logic [WIDTH-1:0] rdata_q;

    // Read register only moves on a read so the last line stays presented.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/l2_mem_responder.sv
`default_nettype none
// ============================================================================
// Module : l2_mem_responder
// Brief  : Fixed-latency line-fill/writeback responder with traffic counters.
// Rev    : 1.0  initial release
// ============================================================================
module l2_mem_responder
    import l2_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BITS  = 512,
    parameter int LG_LINES   = 10,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_req_valid,
    input  logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic [LINE_BITS-1:0]  mem_req_store_data,
    input  logic [3:0]            mem_req_opcode,
    output logic                  mem_rsp_valid,
    output logic [LINE_BITS-1:0]  mem_rsp_load_data,
    output logic                  busy,
    output logic                  bad_opcode,
    output logic [31:0]           load_count,
    output logic [31:0]           store_count
);

    localparam int         OFF_BITS = $clog2(LINE_BITS / 8);
    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    rsp_state_t           state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [LG_LINES-1:0]  idx_q, idx_d;
    logic [3:0]           op_q, op_d;
    logic [LINE_BITS-1:0] wdata_q, wdata_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 data_sel_q, data_sel_d;
    logic                 bad_q, bad_d;
    logic [31:0]          ld_cnt_q, ld_cnt_d;
    logic [31:0]          st_cnt_q, st_cnt_d;
    logic                 ram_we, ram_re;
    logic [LINE_BITS-1:0] ram_rdata;

    // Offset bits and index-aliasing upper bits are deliberately dropped.
    logic unused_offset;
    assign unused_offset = ^mem_req_addr[OFF_BITS-1:0];
    generate
        if (ADDR_WIDTH > OFF_BITS + LG_LINES) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^mem_req_addr[ADDR_WIDTH-1:OFF_BITS+LG_LINES];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        op_d        = op_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        data_sel_d  = data_sel_q;
        bad_d       = bad_q;
        ld_cnt_d    = ld_cnt_q;
        st_cnt_d    = st_cnt_q;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_req_valid) begin
                    idx_d   = mem_req_addr[OFF_BITS +: LG_LINES];
                    op_d    = mem_req_opcode;
                    wdata_d = mem_req_store_data;
                    cnt_d   = CNT_INIT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    // Access issued here so the synchronous read lands in RESP.
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    data_sel_d  = 1'b0;
                    if (op_q == MEM_LD_LINE) begin
                        ram_re     = 1'b1;
                        data_sel_d = 1'b1;
                    end else if (op_q == MEM_ST_LINE) begin
                        ram_we = 1'b1;
                    end else begin
                        bad_d = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_DRAIN;
                if (op_q == MEM_LD_LINE) begin
                    ld_cnt_d = ld_cnt_q + 32'd1;
                end else if (op_q == MEM_ST_LINE) begin
                    st_cnt_d = st_cnt_q + 32'd1;
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            idx_q       <= '0;
            op_q        <= 4'd0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            data_sel_q  <= 1'b0;
            bad_q       <= 1'b0;
            ld_cnt_q    <= 32'd0;
            st_cnt_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            op_q        <= op_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            data_sel_q  <= data_sel_d;
            bad_q       <= bad_d;
            ld_cnt_q    <= ld_cnt_d;
            st_cnt_q    <= st_cnt_d;
        end
    end

    mem_line_ram #(
        .WIDTH    (LINE_BITS),
        .DEPTH_LG (LG_LINES)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (idx_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // Stores and bad opcodes present zero; a load presents the held read line.
    assign mem_rsp_load_data = data_sel_q ? ram_rdata : '0;
    assign mem_rsp_valid     = rsp_valid_q;
    assign busy              = (state_q != ST_IDLE);
    assign bad_opcode        = bad_q;
    assign load_count        = ld_cnt_q;
    assign store_count       = st_cnt_q;

endmodule
`default_nettype wire
